// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the binary GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Worst case is 5*WIDTH+2 compute cycles, so the counter must hold that value.
  function automatic int unsigned cycle_width(input int unsigned width);
    return $clog2(5 * width + 3);
  endfunction

endpackage

// File: rtl/gcd_bin.sv
// Binary (Stein) GCD engine: valid/ready operand intake, result held until the consumer takes it.
module gcd_bin
  import gcd_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = cycle_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    cycles_d = cycles_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          k_d      = '0;
          cycles_d = '0;
          // A zero operand makes the other operand the answer with no compute cycles.
          if (a == '0) begin
            result_d = b;
            state_d  = DONE;
          end else if (b == '0) begin
            result_d = a;
            state_d  = DONE;
          end else begin
            state_d  = SHIFT;
          end
        end
      end

      SHIFT: begin
        cycles_d = cycles_q + CW'(1);
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = SUB;
        end
      end

      SUB: begin
        cycles_d = cycles_q + CW'(1);
        // Both stay odd and nonzero after the shifts, so the subtract never underflows.
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q == b_q) begin
          result_d = a_q << k_q;
          state_d  = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Intake is closed while reset is held so no operand is taken before release.
  assign in_ready  = (state_q == IDLE) && reset;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_bin.sv
// Self-checking bench for gcd_bin (WIDTH=8): directed cases plus a random sweep against a Euclid model.
module tb_gcd_bin;

  localparam int unsigned W     = 8;
  localparam int unsigned CWT   = 6;
  localparam int unsigned BOUND = 5 * W + 2;
  localparam int          NRAND = 1500;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic [CWT-1:0] cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_bin #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cycles    (cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // One full transaction; entered and left just after a rising edge.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input int hold,
                       output logic [W-1:0] r, output logic [CWT-1:0] c);
    int          waitc;
    int          lat;
    int unsigned exp_r;
    exp_r = ref_gcd(32'(ai), 32'(bi));
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a        = ai;
    b        = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Junk on the inputs while busy must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    a        = W'($urandom);
    b        = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", 32'(out_valid), 32'd1);
    check("result", 32'(result), exp_r);
    check("cycles_vs_latency", 32'(cycles), 32'(lat));
    check("cycles_bound", 32'(cycles <= CWT'(BOUND)), 32'd1);
    r = result;
    c = cycles;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), exp_r);
      check("hold_cycles", 32'(cycles), 32'(c));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_result_kept", 32'(result), exp_r);
  endtask

  initial begin
    logic [W-1:0]   r;
    logic [CWT-1:0] c;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // First accept lands on the first rising edge after release.
    do_op(8'd48, 8'd18, 0, r, c);
    check("d48_18_cycles", 32'(c), 32'd8);

    do_op(8'd255, 8'd255, 0, r, c);
    check("d255_cycles", 32'(c), 32'd2);

    do_op(8'd0, 8'd5, 0, r, c);
    check("d0_5_cycles", 32'(c), 32'd0);

    do_op(8'd0, 8'd0, 0, r, c);
    check("d0_0_result", 32'(r), 32'd0);

    do_op(8'd7, 8'd0, 0, r, c);
    check("d7_0_cycles", 32'(c), 32'd0);

    do_op(8'd128, 8'd64, 10, r, c);
    check("d128_64_result", 32'(r), 32'd64);

    // Reset in the middle of an operation.
    a        = 8'd200;
    b        = 8'd150;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("mid_no_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_cycles", 32'(cycles), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
    end
    reset = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    check("mid_rel_result", 32'(result), 32'd0);
    do_op(8'd200, 8'd150, 0, r, c);
    check("d200_150_result", 32'(r), 32'd50);

    for (int i = 0; i < NRAND; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ((i % 16) == 0) ra = '0;
      if ((i % 16) == 8) rb = '0;
      do_op(ra, rb, int'($urandom_range(0, 2)), r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
